// File: rtl/code_memory.sv
// Program code RAM with a byte-stream loader; CPU fetch port is live only in IDLE.
// Optional checksum accumulator compiled in with CODE_MEMORY_CHECKSUM_EN.
module code_memory #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0]    data_out,
  input  logic                     load_start,
  input  logic [ADDRESS_WIDTH:0]   load_words,
  input  logic [7:0]               load_byte,
  input  logic                     load_valid,
  output logic                     load_ready,
  output logic                     busy,
  output logic                     load_done,
  output logic [DATA_WIDTH-1:0]    checksum
);
  localparam int DEPTH = 2**ADDRESS_WIDTH;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [ADDRESS_WIDTH:0] DEPTH_W   = (ADDRESS_WIDTH+1)'(DEPTH);
  localparam logic [BCW-1:0]         LAST_BYTE = BCW'(BYTES-1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH:0]   ptr_q, ptr_d;
  logic [ADDRESS_WIDTH:0]   cnt_q, cnt_d;
  logic [BCW-1:0]           bcnt_q, bcnt_d;
  logic [DATA_WIDTH-1:0]    asm_q, asm_d;
  logic [DATA_WIDTH-1:0]    data_q;
  logic [DATA_WIDTH-1:0]    word;
  logic                     we;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  // Big-endian assembly: earlier bytes end up in the upper lanes.
  assign word = (asm_q << 8) | DATA_WIDTH'(load_byte);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    we      = 1'b0;
    case (state_q)
      IDLE: if (load_start) begin
        ptr_d  = '0;
        bcnt_d = '0;
        asm_d  = '0;
        if (load_words == '0) state_d = DONE;
        else begin
          cnt_d   = (load_words > DEPTH_W) ? DEPTH_W : load_words;
          state_d = LOAD;
        end
      end
      LOAD: if (load_valid) begin
        asm_d = word;
        if (bcnt_q == LAST_BYTE) begin
          we     = 1'b1;
          ptr_d  = ptr_q + 1'b1;
          bcnt_d = '0;
          if (ptr_d == cnt_q) state_d = DONE;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      data_q  <= mem_q[address];
    end
  end

  // Contents survive reset; only the write strobe is suppressed.
  always_ff @(posedge clk) begin
    if (we && !reset) mem_q[ptr_q[ADDRESS_WIDTH-1:0]] <= word;
  end

  assign data_out   = (state_q == IDLE) ? data_q : '0;
  assign busy       = (state_q != IDLE);
  assign load_ready = (state_q == LOAD);
  assign load_done  = (state_q == DONE);

`ifdef CODE_MEMORY_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;
  logic                  start_acc;
  assign start_acc = (state_q == IDLE) && load_start;

  always_ff @(posedge clk) begin
    if (reset)          csum_q <= '0;
    else if (start_acc) csum_q <= '0;
    else if (we)        csum_q <= csum_q + word;
  end
  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_code_memory.sv
// Directed bench for code_memory: load sequences, fetch-read table, reset and clamp corners.
module tb_code_memory;
  localparam int AW = 4;
  localparam int DW = 16;
`ifdef CODE_MEMORY_CHECKSUM_EN
  localparam bit CS_ON = 1'b1;
`else
  localparam bit CS_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic [DW-1:0] data_out;
  logic          load_start;
  logic [AW:0]   load_words;
  logic [7:0]    load_byte;
  logic          load_valid;
  logic          load_ready;
  logic          busy;
  logic          load_done;
  logic [DW-1:0] checksum;

  code_memory #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .address(address), .data_out(data_out),
    .load_start(load_start), .load_words(load_words), .load_byte(load_byte),
    .load_valid(load_valid), .load_ready(load_ready), .busy(busy),
    .load_done(load_done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            phase;
    logic [AW-1:0] addr;
    logic [DW-1:0] exp;
  } rd_vec_t;

  rd_vec_t rd_tab[15];
  int total = 0;
  int passed = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic start_load(input logic [AW:0] n);
    load_start = 1'b1;
    load_words = n;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_byte  = b;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic run_reads(input int ph);
    for (int i = 0; i < 15; i++) begin
      if (rd_tab[i].phase == ph) begin
        address = rd_tab[i].addr;
        tick();
        chk($sformatf("read_p%0d_a%0d", ph, rd_tab[i].addr), data_out, rd_tab[i].exp);
      end
    end
  endtask

  initial begin
    logic [7:0] b3 [6];
    b3 = '{8'h80, 8'h00, 8'h00, 8'hFF, 8'h48, 8'h00};
    rd_tab = '{
      '{1, 4'd0,  16'h8000}, '{1, 4'd1,  16'h00FF}, '{1, 4'd2,  16'h4800}, '{1, 4'd5, 16'h0000},
      '{2, 4'd0,  16'hA1B2}, '{2, 4'd1,  16'hC3D4}, '{2, 4'd2,  16'h4800},
      '{3, 4'd0,  16'h1234}, '{3, 4'd1,  16'hC3D4},
      '{4, 4'd0,  16'h1234},
      '{5, 4'd0,  16'hABCD}, '{5, 4'd1,  16'hC3D4},
      '{6, 4'd0,  16'h0010}, '{6, 4'd7,  16'h0717}, '{6, 4'd15, 16'h0F1F}
    };

    reset = 1'b1; address = '0; load_start = 1'b0; load_words = '0;
    load_byte = '0; load_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_ready", load_ready, 0);
    chk("rst_done", load_done, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_csum", checksum, 0);

    // 3-word gap-free load
    start_load(5'd3);
    chk("l3_busy", busy, 1);
    chk("l3_ready", load_ready, 1);
    for (int i = 0; i < 6; i++) begin
      send_byte(b3[i]);
      chk($sformatf("l3_done_b%0d", i), load_done, (i == 5) ? 1 : 0);
      if (i < 5) chk($sformatf("l3_dout_b%0d", i), data_out, 0);
    end
    chk("l3_csum", checksum, CS_ON ? 32'hC8FF : 32'h0);
    tick();
    chk("l3_done_once", load_done, 0);
    chk("l3_idle", busy, 0);
    run_reads(1);

    // 2-word load with a 4-cycle gap between bytes 2 and 3
    start_load(5'd2);
    send_byte(8'hA1);
    send_byte(8'hB2);
    for (int g = 0; g < 4; g++) begin
      tick();
      chk($sformatf("gap_busy_%0d", g), busy, 1);
      chk($sformatf("gap_dout_%0d", g), data_out, 0);
      chk($sformatf("gap_done_%0d", g), load_done, 0);
    end
    send_byte(8'hC3);
    chk("gap_busy_b3", busy, 1);
    send_byte(8'hD4);
    chk("gap_done", load_done, 1);
    chk("gap_csum", checksum, CS_ON ? 32'h6586 : 32'h0);
    tick();
    run_reads(2);

    // reset after byte 3 of a 2-word load
    start_load(5'd2);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    reset = 1'b1; load_valid = 1'b1; load_byte = 8'h78; load_start = 1'b1; load_words = 5'd1;
    tick();
    reset = 1'b0; load_valid = 1'b0; load_start = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", load_done, 0);
    chk("mrst_csum", checksum, 0);
    run_reads(3);

    // zero-word load
    start_load(5'd0);
    chk("z_busy", busy, 1);
    chk("z_done", load_done, 1);
    chk("z_ready", load_ready, 0);
    tick();
    chk("z_idle", busy, 0);
    chk("z_done_clr", load_done, 0);
    chk("z_csum", checksum, 0);
    run_reads(4);

    // load_start during LOAD must not change the latched count
    start_load(5'd1);
    load_start = 1'b1; load_words = 5'd5;
    send_byte(8'hAB);
    load_start = 1'b0;
    chk("ign_busy", busy, 1);
    send_byte(8'hCD);
    chk("ign_done", load_done, 1);
    chk("ign_csum", checksum, CS_ON ? 32'hABCD : 32'h0);
    tick();
    run_reads(5);

    // count larger than depth clamps to DEPTH and stops at the last address
    start_load(5'd20);
    for (int w = 0; w < 16; w++) begin
      send_byte(8'(w));
      send_byte(8'(8'h10 + w));
      if (w == 14) chk("clamp_not_done", load_done, 0);
    end
    chk("clamp_done", load_done, 1);
    chk("clamp_ready", load_ready, 0);
    chk("clamp_csum", checksum, CS_ON ? 32'h7978 : 32'h0);
    send_byte(8'hEE);
    chk("clamp_idle", busy, 0);
    run_reads(6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/code_memory.md
CODE_MEMORY -- requirements
Module: code_memory

Interface
REQ-001 SHALL provide parameter ADDRESS_WIDTH, default 10, word-address width (depth = 2**ADDRESS_WIDTH words).
REQ-002 SHALL provide parameter DATA_WIDTH, default 16, word width; legal values are multiples of 8, 8 to 32 (BYTES = DATA_WIDTH/8).
REQ-003 SHALL provide port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port address  input  ADDRESS_WIDTH  CPU fetch word address.
REQ-006 SHALL provide port data_out  output  DATA_WIDTH  registered fetch data.
REQ-007 SHALL provide port load_start  input  1  single-cycle request to begin a program load.
REQ-008 SHALL provide port load_words  input  ADDRESS_WIDTH+1  number of words to load, sampled with load_start.
REQ-009 SHALL provide port load_byte  input  8  loader byte stream.
REQ-010 SHALL provide port load_valid  input  1  load_byte is valid.
REQ-011 SHALL provide port load_ready  output  1  block accepts load_byte this cycle.
REQ-012 SHALL provide port busy  output  1  load in progress; CPU shall be held.
REQ-013 SHALL provide port load_done  output  1  single-cycle pulse at load completion.
REQ-014 SHALL provide port checksum  output  DATA_WIDTH  modular sum of words written by the last load.

Function
REQ-015 SHALL implement a DEPTH x DATA_WIDTH synchronous RAM; power-up contents all zero; reset never alters contents.
REQ-016 SHALL, in IDLE, present mem[address] on data_out one clock after address is applied (latency 1).
REQ-017 SHALL drive data_out to 0 whenever state is not IDLE.
REQ-018 SHALL use states IDLE, LOAD, DONE; busy = (state != IDLE); load_ready = (state == LOAD).
REQ-019 SHALL, on load_start in IDLE, latch min(load_words, DEPTH), clear write pointer and byte counter, enter LOAD.
REQ-020 SHALL, on load_start with load_words = 0, go IDLE -> DONE directly, writing nothing.
REQ-021 SHALL accept a byte on each cycle with load_valid && load_ready; byte shifts into an assembly register MSB-first (big-endian).
REQ-022 SHALL, on acceptance of byte BYTES-1 of a word, write the assembled word to mem[pointer] in that same clock edge, increment pointer, reset byte counter.
REQ-023 SHALL, when the write makes pointer equal the latched count, transition LOAD -> DONE on that edge.
REQ-024 SHALL stay in DONE exactly one cycle with load_done = 1, then return to IDLE.
REQ-025 SHALL ignore load_start while in LOAD or DONE.
REQ-026 SHALL not advance the byte counter on cycles with load_valid = 0 (gaps arbitrary length).
REQ-027 SHALL not wrap the pointer; a count clamped to DEPTH fills addresses 0..DEPTH-1 then ends.

Reset
REQ-028 SHALL, on reset, enter IDLE and clear data_out, pointer, byte counter, assembly register, load_done and checksum to 0.
REQ-029 SHALL, on reset mid-load, abandon the load; words already written remain in memory; partial word is discarded.
REQ-030 SHALL give reset priority over load_start and load_valid in the same cycle.

Configuration
REQ-031 SHALL compile the checksum accumulator only when macro CODE_MEMORY_CHECKSUM_EN is defined.
REQ-032 SHALL, with CODE_MEMORY_CHECKSUM_EN, clear checksum on accepted load_start and add each written word modulo 2**DATA_WIDTH; value stable from load_done until next load_start.
REQ-033 SHALL, without CODE_MEMORY_CHECKSUM_EN, keep the checksum port and tie it to constant 0.

Verification
REQ-034 Load 3 words, bytes 80 00 00 FF 48 00, valid every cycle -> mem[0..2] = 8000, 00FF, 4800; load_done pulses once, the cycle after the sixth byte is accepted; checksum = C8FF (with macro) or 0000 (without).
REQ-035 After REQ-034 load, address 1 applied in IDLE -> data_out = 00FF on next edge; address 5 -> 0000.
REQ-036 Load 2 words with load_valid low for 4 cycles between bytes 2 and 3 -> same result as gap-free; busy high throughout, data_out = 0 during load.
REQ-037 Reset asserted after byte 3 of a 2-word load (word 0 = 1234) -> state IDLE next cycle, mem[0] = 1234, mem[1] unchanged, checksum = 0.
REQ-038 load_start with load_words = 0 -> busy high one cycle, load_done pulse, no memory change; load_start during LOAD ignored (count unchanged).
